// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory port: FSM states, funct3 encodings
// and the legality check applied before a bus cycle is started.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants are load-only; halves need even, words need 4-byte alignment.
  function automatic logic access_legal(input logic [2:0] funct3, input logic [1:0] offset,
                                        input logic is_write);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !is_write;
      F3_H:    ok = (offset[0] == 1'b0);
      F3_HU:   ok = !is_write && (offset[0] == 1'b0);
      F3_W:    ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load-data steering: picks the addressed byte/half lane from the bus word and
// sign- or zero-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = bus_rdata[{offset, 3'b000} +: 8];
  assign lane_h = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    rdata = bus_rdata;
    case (funct3)
      F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
      F3_BU:   rdata = {24'h0, lane_b};
      F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
      F3_HU:   rdata = {16'h0, lane_h};
      default: rdata = bus_rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_port.sv
// Data-memory endpoint for the EX/MEM stage: turns MemRead/MemWrite into a single
// outstanding req/ack bus cycle, stalling the pipeline until ack or timeout.
module data_mem_port
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              access_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;

  logic              req_in;
  logic              legal;
  logic [31:0]       wdata_st;
  logic [3:0]        be_st;
  logic [31:0]       load_data;

  assign req_in = mem_read | mem_write;
  // mem_write takes priority, so a simultaneous read is checked as a store.
  assign legal  = access_legal(funct3, addr[1:0], mem_write);

  always_comb begin
    wdata_st = wdata;
    be_st    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_st = {4{wdata[7:0]}};
        be_st    = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_st = {2{wdata[15:0]}};
        be_st    = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  // Extension uses the copies captured at request time, not the live inputs.
  load_align u_load_align (
    .funct3    (f3_q),
    .offset    (off_q),
    .bus_rdata (bus_rdata),
    .rdata     (load_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    off_d   = off_q;
    f3_d    = f3_q;
    unique case (state_q)
      IDLE: begin
        if (req_in) begin
          if (legal) begin
            state_d = ACCESS;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            wdata_d = wdata_st;
            be_d    = mem_write ? be_st : 4'b1111;
            off_d   = addr[1:0];
            f3_d    = funct3;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (bus_ack) begin
          rdata_d = load_data;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      off_q   <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
    end
  end

  assign stall      = (state_q == ACCESS) || ((state_q == IDLE) && req_in && legal);
  assign access_err = err_q;
  assign bus_req    = req_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_be     = be_q;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_data_mem_port.sv
// Directed bench for data_mem_port: stores, loads with extension, illegal accesses,
// bus timeout and asynchronous reset during an access.
module tb_data_mem_port;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        access_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_port #(
    .ADDR_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .access_err (access_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] word, input logic [31:0] exp);
    @(negedge clk);
    mem_read = 1'b1; funct3 = f3; addr = a;
    #1 check_eq({tag, "_stall0"}, 32'(stall), 32'd1);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = word;
    #1;
    check_eq({tag, "_req"}, 32'(bus_req), 32'd1);
    check_eq({tag, "_we"}, 32'(bus_we), 32'd0);
    check_eq({tag, "_be"}, 32'(bus_be), 32'hF);
    check_eq({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    @(negedge clk);
    bus_ack = 1'b0; mem_read = 1'b0;
    #1;
    check_eq({tag, "_rdata"}, rdata, exp);
    check_eq({tag, "_done_stall"}, 32'(stall), 32'd0);
    check_eq({tag, "_done_req"}, 32'(bus_req), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_addr);
    @(negedge clk);
    mem_write = 1'b1; funct3 = f3; addr = a; wdata = d;
    #1 check_eq({tag, "_stall0"}, 32'(stall), 32'd1);
    @(negedge clk);
    bus_ack = 1'b1;
    #1;
    check_eq({tag, "_we"}, 32'(bus_we), 32'd1);
    check_eq({tag, "_be"}, 32'(bus_be), 32'(exp_be));
    check_eq({tag, "_wdata"}, bus_wdata, exp_wd);
    check_eq({tag, "_addr"}, bus_addr, exp_addr);
    @(negedge clk);
    bus_ack = 1'b0; mem_write = 1'b0;
    #1 check_eq({tag, "_done_stall"}, 32'(stall), 32'd0);
  endtask

  task automatic do_illegal(input string tag, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a);
    @(negedge clk);
    mem_read = !wr; mem_write = wr; funct3 = f3; addr = a;
    #1 check_eq({tag, "_stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #1;
    check_eq({tag, "_err"}, 32'(access_err), 32'd1);
    check_eq({tag, "_req"}, 32'(bus_req), 32'd0);
    @(negedge clk);
    #1 check_eq({tag, "_err_off"}, 32'(access_err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    #2;
    check_eq("rst_req", 32'(bus_req), 32'd0);
    check_eq("rst_be", 32'(bus_be), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_err", 32'(access_err), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // SW with ack in the second ACCESS cycle: stall high three cycles, then low one.
    @(negedge clk);
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'hDEADBEEF;
    #1 check_eq("sw_stall_c0", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    check_eq("sw_stall_c1", 32'(stall), 32'd1);
    check_eq("sw_req", 32'(bus_req), 32'd1);
    check_eq("sw_we", 32'(bus_we), 32'd1);
    check_eq("sw_be", 32'(bus_be), 32'hF);
    check_eq("sw_addr", bus_addr, 32'h100);
    check_eq("sw_wdata", bus_wdata, 32'hDEADBEEF);
    @(negedge clk);
    bus_ack = 1'b1;
    #1;
    check_eq("sw_stall_c2", 32'(stall), 32'd1);
    check_eq("sw_req_c2", 32'(bus_req), 32'd1);
    @(negedge clk);
    bus_ack = 1'b0; mem_write = 1'b0;
    #1;
    check_eq("sw_stall_done", 32'(stall), 32'd0);
    check_eq("sw_req_done", 32'(bus_req), 32'd0);
    check_eq("sw_err_done", 32'(access_err), 32'd0);

    do_load("lb", 3'b000, 32'h203, 32'h80112233, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h203, 32'h80112233, 32'h00000080);
    do_load("lb1", 3'b000, 32'h201, 32'h80112233, 32'h00000022);
    do_load("lh", 3'b001, 32'h202, 32'h80112233, 32'hFFFF8011);
    do_load("lhu", 3'b101, 32'h202, 32'h80112233, 32'h00008011);
    do_load("lh0", 3'b001, 32'h200, 32'h8011A233, 32'hFFFFA233);
    do_load("lw", 3'b010, 32'h204, 32'h80112233, 32'h80112233);

    do_store("sh", 3'b001, 32'h0A, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, 32'h08);
    do_store("sb", 3'b000, 32'h101, 32'h12345677, 4'b0010, 32'h77777777, 32'h100);
    do_store("sb3", 3'b000, 32'h0F, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h0C);

    do_illegal("lw_mis", 1'b0, 3'b010, 32'h102);
    do_illegal("lh_odd", 1'b0, 3'b001, 32'h103);
    do_illegal("sbu", 1'b1, 3'b100, 32'h100);
    do_illegal("f3_bad", 1'b0, 3'b011, 32'h100);

    // Timeout with TIMEOUT=4: four request cycles, then DONE with error and zeroed rdata.
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("to_req_%0d", i), 32'(bus_req), 32'd1);
      check_eq($sformatf("to_err_%0d", i), 32'(access_err), 32'd0);
      check_eq($sformatf("to_stall_%0d", i), 32'(stall), 32'd1);
    end
    @(negedge clk);
    mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
    #1;
    check_eq("to_req_done", 32'(bus_req), 32'd0);
    check_eq("to_err_done", 32'(access_err), 32'd1);
    check_eq("to_rdata", rdata, 32'd0);
    check_eq("to_stall_done", 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    check_eq("late_ack_req", 32'(bus_req), 32'd0);
    check_eq("late_ack_rdata", rdata, 32'd0);
    check_eq("late_ack_err", 32'(access_err), 32'd0);
    bus_ack = 1'b0;

    // Reset asserted in the middle of an ACCESS cycle, away from any clock edge.
    @(negedge clk);
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h400; wdata = 32'hCAFEF00D;
    @(negedge clk);
    #1 check_eq("rm_req_before", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rm_req", 32'(bus_req), 32'd0);
    check_eq("rm_we", 32'(bus_we), 32'd0);
    check_eq("rm_addr", bus_addr, 32'd0);
    check_eq("rm_wdata", bus_wdata, 32'd0);
    check_eq("rm_be", 32'(bus_be), 32'd0);
    mem_write = 1'b0; bus_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_eq("rm_ack_req", 32'(bus_req), 32'd0);
    check_eq("rm_ack_stall", 32'(stall), 32'd0);
    check_eq("rm_ack_rdata", rdata, 32'd0);
    check_eq("rm_ack_err", 32'(access_err), 32'd0);
    bus_ack = 1'b0;

    // Post-reset load proves the FSM returned to IDLE.
    do_load("post_rst", 3'b000, 32'h500, 32'h0000007F, 32'h0000007F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
